// File: rtl/jtag_host_shifter_if.sv
// jtag_host_shifter_if
// Bundles the command/response handshake, the status flag and the JTAG pins
// of the JTAG host shifter so they can be passed around as one port.
//   cmd_valid/cmd_ready/cmd_is_ir/cmd_len/cmd_data : scan request channel
//   rsp_valid/rsp_err/rsp_data                     : scan completion channel
//   busy                                           : shifter is not idle
//   tck/tms/tdi (to target) and tdo (from target)  : JTAG wires
// The slave modport is the shifter itself; master is whoever issues scans
// and also plays the target TAP.
interface jtag_host_shifter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_is_ir;
  logic [5:0]  cmd_len;
  logic [37:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic [37:0] rsp_data;
  logic        busy;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        tdo;

  modport slave (
    input  cmd_valid, cmd_is_ir, cmd_len, cmd_data, tdo,
    output cmd_ready, rsp_valid, rsp_err, rsp_data, busy, tck, tms, tdi
  );

  modport master (
    output cmd_valid, cmd_is_ir, cmd_len, cmd_data, tdo,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data, busy, tck, tms, tdi
  );
endinterface

// File: rtl/jtag_host_shifter.sv
// jtag_host_shifter
// Drives a JTAG TAP from a simple command interface. After reset the TAP is
// walked to Run-Test/Idle via Test-Logic-Reset; each accepted command then
// performs one IR or DR scan of cmd_len bits (LSB first) and returns the
// captured TDO bits on the response channel.
// Ports:
//   clk    : system clock, everything is clocked on its rising edge
//   reset  : asynchronous active-high reset
//   bus    : jtag_host_shifter_if.slave (command, response, busy, JTAG pins)
// Parameters:
//   CLK_DIV : TCK half-period in clk cycles (1..255)
//   MAX_LEN : longest legal scan in bits
module jtag_host_shifter #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 38
) (
  input  logic                clk,
  input  logic                reset,
  jtag_host_shifter_if.slave  bus
);

  typedef enum logic [2:0] {
    TLR_SEQ,
    IDLE,
    SELECT,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    DONE
  } state_t;

  localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [6:0] MAX_LEN_W   = 7'(MAX_LEN);

  state_t      state_q, state_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        isIr_q, isIr_d;
  logic [5:0]  len_q, len_d;
  logic [37:0] data_q, data_d;
  logic [37:0] cap_q, cap_d;
  logic [37:0] rspData_q, rspData_d;
  logic        rspErr_q, rspErr_d;

  logic        halfEnd;
  logic        tickEnd;
  logic        lenBad;
  logic        lastBit;
  logic [5:0]  cntInc;

  // State and datapath registers. Reset parks the pins in the TLR-entry
  // pattern (tck low, tms high) so the reset sequence starts cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TLR_SEQ;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      isIr_q    <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      cap_q     <= '0;
      rspData_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      isIr_q    <= isIr_d;
      len_q     <= len_d;
      data_q    <= data_d;
      cap_q     <= cap_d;
      rspData_q <= rspData_d;
      rspErr_q  <= rspErr_d;
    end
  end

  // Next-state logic. Every non-idle state except DONE is made of whole
  // ticks; tms/tdi for the next tick are only chosen at the end of a tick,
  // i.e. on the edge that drives tck low, so they are stable while tck is high.
  always_comb begin
    state_d   = state_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    isIr_d    = isIr_q;
    len_d     = len_q;
    data_d    = data_q;
    cap_d     = cap_q;
    rspData_d = rspData_q;
    rspErr_d  = rspErr_q;

    halfEnd = (div_q == DIV_LAST);
    tickEnd = halfEnd && tck_q;
    cntInc  = cnt_q + 6'd1;
    lastBit = (cnt_q == (len_q - 6'd1));
    lenBad  = (bus.cmd_len == 6'd0) || ({1'b0, bus.cmd_len} > MAX_LEN_W);

    case (state_q)
      IDLE: begin
        tck_d = 1'b0;
        tms_d = 1'b0;
        tdi_d = 1'b0;
        if (bus.cmd_valid) begin
          isIr_d = bus.cmd_is_ir;
          len_d  = bus.cmd_len;
          data_d = bus.cmd_data;
          cnt_d  = '0;
          div_d  = '0;
          if (lenBad) begin
            // Illegal length: answer straight away without touching the TAP.
            state_d  = DONE;
            rspErr_d = 1'b1;
          end else begin
            state_d = SELECT;
            tms_d   = 1'b1;
            cap_d   = '0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        if (halfEnd) begin
          div_d = '0;
          tck_d = ~tck_q;
        end else begin
          div_d = div_q + 8'd1;
        end

        // tdo is captured on the edge that raises tck.
        if (halfEnd && !tck_q && (state_q == SHIFT)) begin
          cap_d[cnt_q] = bus.tdo;
        end

        if (tickEnd) begin
          case (state_q)
            TLR_SEQ: begin
              // Five tms=1 ticks reach Test-Logic-Reset, the sixth (tms=0)
              // lands in Run-Test/Idle.
              if (cnt_q == 6'd5) begin
                state_d = IDLE;
                cnt_d   = '0;
                tms_d   = 1'b0;
              end else begin
                cnt_d = cntInc;
                tms_d = (cntInc < 6'd5);
              end
            end
            SELECT: begin
              // IR scans take a second tms=1 tick to reach Select-IR.
              if (isIr_q && (cnt_q == 6'd0)) begin
                cnt_d = 6'd1;
                tms_d = 1'b1;
              end else begin
                state_d = CAPTURE;
                cnt_d   = '0;
                tms_d   = 1'b0;
              end
            end
            CAPTURE: begin
              // Two tms=0 ticks: Capture, then the move into Shift.
              if (cnt_q == 6'd0) begin
                cnt_d = 6'd1;
                tms_d = 1'b0;
              end else begin
                state_d = SHIFT;
                cnt_d   = '0;
                tms_d   = (len_q == 6'd1);
                tdi_d   = data_q[0];
              end
            end
            SHIFT: begin
              if (lastBit) begin
                state_d = EXIT1;
                tms_d   = 1'b1;
                tdi_d   = 1'b0;
              end else begin
                cnt_d = cntInc;
                tdi_d = data_q[cntInc];
                tms_d = (cntInc == (len_q - 6'd1));
              end
            end
            EXIT1: begin
              state_d = UPDATE;
              tms_d   = 1'b0;
            end
            UPDATE: begin
              state_d   = DONE;
              tms_d     = 1'b0;
              rspData_d = cap_q;
              rspErr_d  = 1'b0;
            end
            default: begin
              state_d = state_q;
            end
          endcase
        end
      end
    endcase
  end

  assign bus.tck       = tck_q;
  assign bus.tms       = tms_q;
  assign bus.tdi       = tdi_q;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_err   = rspErr_q;
  assign bus.rsp_data  = rspData_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// tb_jtag_host_shifter
// Directed bench for jtag_host_shifter with CLK_DIV=2, MAX_LEN=38. The target
// TAP is modelled as either a tdi->tdo loopback or tdo tied high.
module tb_jtag_host_shifter;

  logic clk;
  logic reset;
  logic tdoTied;

  int total;
  int bad;
  int tckRises;
  int acceptCnt;
  int stabViol;
  bit recordEn;
  logic tmsLog[$];
  logic tdiLog[$];
  logic prevTms;
  logic prevTdi;

  jtag_host_shifter_if bus();

  jtag_host_shifter #(
    .CLK_DIV(2),
    .MAX_LEN(38)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Target TAP model: loopback or constant one.
  assign bus.tdo = tdoTied ? 1'b1 : bus.tdi;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log tms/tdi as seen by the target on each rising tck.
  always @(posedge bus.tck) begin
    tckRises++;
    if (recordEn) begin
      tmsLog.push_back(bus.tms);
      tdiLog.push_back(bus.tdi);
    end
  end

  // Count handshakes as the DUT sees them.
  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) acceptCnt++;
  end

  // Any tms/tdi change that shows up while tck is high is a violation.
  always @(negedge clk) begin
    if (bus.tck === 1'b1 && (bus.tms !== prevTms || bus.tdi !== prevTdi)) stabViol++;
    prevTms = bus.tms;
    prevTdi = bus.tdi;
  end

  // Presents one command and waits (bounded) for it to be accepted.
  // Returns #1 after the accepting edge.
  task automatic sendCmd(input logic isIr, input logic [5:0] len, input logic [37:0] data,
                         input bit holdValid, output bit ok);
    ok = 1'b0;
    bus.cmd_is_ir = isIr;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!holdValid) bus.cmd_valid = 1'b0;
  endtask

  // Counts clk edges until rsp_valid is seen; -1 if it never comes.
  task automatic waitRsp(output int n);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.rsp_valid !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    logic expTck, expTms, expRdy;
    #1;
    total++;
    if ({bus.tck, bus.tms, bus.tdi} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL reset_pins: got tck/tms/tdi=%b expected 010", {bus.tck, bus.tms, bus.tdi});
    end
    total++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.busy} !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL reset_flags: got rdy/val/err/busy=%b expected 0001",
               {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.busy});
    end
    total++;
    if (bus.rsp_data !== 38'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: got %h expected 0", bus.rsp_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      #1;
      expTms = (n < 20);
      expTck = (n < 24) ? ((n % 4) >= 2) : 1'b0;
      expRdy = (n == 24);
      total++;
      if ({bus.tck, bus.tms, bus.cmd_ready} !== {expTck, expTms, expRdy}) begin
        bad++;
        $display("[TB] FAIL tlr_seq cycle %0d: got tck/tms/rdy=%b expected %b",
                 n, {bus.tck, bus.tms, bus.cmd_ready}, {expTck, expTms, expRdy});
      end
    end
  endtask

  task automatic test_dr_loop();
    bit ok;
    int n;
    tdoTied = 1'b0;
    sendCmd(1'b0, 6'd38, 38'h2A_5A5A_A5A5, 1'b0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL dr_accept: got no accept expected accept");
    end
    waitRsp(n);
    total++;
    if (n !== 172) begin
      bad++;
      $display("[TB] FAIL dr_latency: got %0d expected 172", n);
    end
    total++;
    if (bus.rsp_data !== 38'h2A_5A5A_A5A5 || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dr_data: got %h err=%b expected 2a5a5aa5a5 err=0", bus.rsp_data, bus.rsp_err);
    end
    @(posedge clk);
    #1;
    total++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL dr_done_to_idle: got val/rdy=%b expected 01", {bus.rsp_valid, bus.cmd_ready});
    end
  endtask

  task automatic test_ir_tied();
    bit ok;
    int n;
    logic [7:0] tmsSeq;
    logic [7:0] tdiSeq;
    tdoTied = 1'b1;
    tmsLog.delete();
    tdiLog.delete();
    recordEn = 1'b1;
    sendCmd(1'b1, 6'd2, 38'h2, 1'b0, ok);
    waitRsp(n);
    recordEn = 1'b0;
    tdoTied = 1'b0;
    total++;
    if (n !== 32) begin
      bad++;
      $display("[TB] FAIL ir_latency: got %0d expected 32", n);
    end
    tmsSeq = '0;
    tdiSeq = '0;
    for (int i = 0; i < 8 && i < tmsLog.size(); i++) begin
      tmsSeq[i] = tmsLog[i];
      tdiSeq[i] = tdiLog[i];
    end
    total++;
    if (tmsLog.size() !== 8 || tmsSeq !== 8'b0110_0011) begin
      bad++;
      $display("[TB] FAIL ir_tms: got %0d ticks seq=%b expected 8 ticks seq=01100011", tmsLog.size(), tmsSeq);
    end
    total++;
    if (tdiSeq !== 8'b0010_0000) begin
      bad++;
      $display("[TB] FAIL ir_tdi: got %b expected 00100000", tdiSeq);
    end
    total++;
    if (bus.rsp_data !== 38'h3 || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ir_data: got %h err=%b expected 3 err=0", bus.rsp_data, bus.rsp_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_len();
    bit ok;
    int rises0;
    logic [5:0] badLens[2];
    badLens[0] = 6'd0;
    badLens[1] = 6'd39;
    rises0 = tckRises;
    foreach (badLens[i]) begin
      sendCmd(1'b0, badLens[i], 38'h3F_FFFF_FFFF, 1'b0, ok);
      total++;
      if (!ok || {bus.rsp_valid, bus.rsp_err} !== 2'b11) begin
        bad++;
        $display("[TB] FAIL bad_len_%0d_rsp: got ok=%b val/err=%b expected 1 11",
                 badLens[i], ok, {bus.rsp_valid, bus.rsp_err});
      end
      total++;
      if (bus.rsp_data !== 38'h3) begin
        bad++;
        $display("[TB] FAIL bad_len_%0d_data: got %h expected 3", badLens[i], bus.rsp_data);
      end
      @(posedge clk);
      #1;
      total++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
        bad++;
        $display("[TB] FAIL bad_len_%0d_idle: got val/rdy=%b expected 01", badLens[i], {bus.rsp_valid, bus.cmd_ready});
      end
    end
    total++;
    if (tckRises !== rises0) begin
      bad++;
      $display("[TB] FAIL bad_len_tck: got %0d tck rises expected 0", tckRises - rises0);
    end
  endtask

  task automatic test_len_one();
    bit ok;
    int n;
    logic [5:0] tmsSeq;
    tmsLog.delete();
    tdiLog.delete();
    recordEn = 1'b1;
    sendCmd(1'b0, 6'd1, 38'h1, 1'b0, ok);
    waitRsp(n);
    recordEn = 1'b0;
    total++;
    if (n !== 24) begin
      bad++;
      $display("[TB] FAIL len1_latency: got %0d expected 24", n);
    end
    tmsSeq = '0;
    for (int i = 0; i < 6 && i < tmsLog.size(); i++) tmsSeq[i] = tmsLog[i];
    total++;
    if (tmsLog.size() !== 6 || tmsSeq !== 6'b011001) begin
      bad++;
      $display("[TB] FAIL len1_tms: got %0d ticks seq=%b expected 6 ticks seq=011001", tmsLog.size(), tmsSeq);
    end
    total++;
    if (bus.rsp_data !== 38'h1 || bus.rsp_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL len1_data: got %h err=%b expected 1 err=0", bus.rsp_data, bus.rsp_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    bit sawValid;
    bit earlyReady;
    sendCmd(1'b0, 6'd38, 38'h15_0F0F_F0F0, 1'b0, ok);
    repeat (53) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.tck, bus.tms, bus.tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.busy} !== 7'b0100001
        || bus.rsp_data !== 38'h0) begin
      bad++;
      $display("[TB] FAIL midreset_values: got tck/tms/tdi/rdy/val/err/busy=%b data=%h expected 0100001 data=0",
               {bus.tck, bus.tms, bus.tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.busy}, bus.rsp_data);
    end
    @(negedge clk);
    reset = 1'b0;
    sawValid = 1'b0;
    earlyReady = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) sawValid = 1'b1;
      if (c < 24 && bus.cmd_ready === 1'b1) earlyReady = 1'b1;
    end
    total++;
    if (sawValid || earlyReady || bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_tlr: got valid=%b early=%b rdy@24=%b expected 0 0 1",
               sawValid, earlyReady, bus.cmd_ready);
    end
    sendCmd(1'b0, 6'd8, 38'hC3, 1'b0, ok);
    waitRsp(n);
    total++;
    if (n !== 52 || bus.rsp_data !== 38'hC3) begin
      bad++;
      $display("[TB] FAIL midreset_next: got lat=%0d data=%h expected 52 c3", n, bus.rsp_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    acceptCnt = 0;
    sendCmd(1'b0, 6'd8, 38'h5A, 1'b1, ok);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 1000) begin
      bus.cmd_data  = {6'($urandom), $urandom};
      bus.cmd_len   = 6'd3;
      bus.cmd_is_ir = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    total++;
    if (n !== 52 || bus.rsp_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_latency: got %0d expected 52", n);
    end
    total++;
    if (bus.rsp_data !== 38'h5A) begin
      bad++;
      $display("[TB] FAIL b2b_data: got %h expected 5a", bus.rsp_data);
    end
    @(posedge clk);
    #1;
    total++;
    if (acceptCnt !== 1) begin
      bad++;
      $display("[TB] FAIL b2b_accepts: got %0d expected 1", acceptCnt);
    end
    total++;
    if (stabViol !== 0) begin
      bad++;
      $display("[TB] FAIL pin_stability: got %0d changes while tck high expected 0", stabViol);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    tckRises = 0;
    acceptCnt = 0;
    stabViol = 0;
    recordEn = 1'b0;
    prevTms = 1'b1;
    prevTdi = 1'b0;
    tdoTied = 1'b0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_is_ir = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;

    test_reset();
    test_dr_loop();
    test_ir_tied();
    test_bad_len();
    test_len_one();
    test_reset_mid();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_host_shifter.md
JTAG_HOST_SHIFTER -- requirements
Module: jtag_host_shifter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning TCK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter MAX_LEN, default 38, meaning the maximum shift length in bits (matches the debug-slave DR width).
REQ-003 SHALL use one clock and an asynchronous, active-high reset; all logic SHALL be clocked on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted on a clk edge where cmd_valid and cmd_ready are both high.
REQ-008 cmd_is_ir  input  1  1 = IR scan, 0 = DR scan.
REQ-009 cmd_len  input  6  number of bits to shift.
REQ-010 cmd_data  input  38  TDI data, LSB shifted first.
REQ-011 rsp_valid  output  1  one-cycle pulse marking scan completion.
REQ-012 rsp_err  output  1  qualifies rsp_valid; 1 = illegal length.
REQ-013 rsp_data  output  38  captured TDO bits, held until the next rsp_valid.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 tck, tms, tdi  output  1 each  JTAG drive to the target TAP.
REQ-016 tdo  input  1  JTAG return from the target TAP.

Function
REQ-017 A tick SHALL consist of CLK_DIV clk cycles with tck=0 followed by CLK_DIV cycles with tck=1.
REQ-018 tms and tdi SHALL change only on the clk edge that drives tck low, and SHALL stay stable for the whole tick.
REQ-019 tdo SHALL be sampled on the clk edge that drives tck high, and only during SHIFT ticks.
REQ-020 FSM states SHALL be TLR_SEQ, IDLE, SELECT, CAPTURE, SHIFT, EXIT1, UPDATE, DONE.
REQ-021 TLR_SEQ SHALL issue 5 ticks with tms=1, then 1 tick with tms=0, then enter IDLE (TAP left in Run-Test/Idle).
REQ-022 In IDLE: tck=0 and tms=0, and cmd_ready=1; in every other state cmd_ready=0.
REQ-023 On acceptance, cmd_is_ir, cmd_len and cmd_data SHALL be registered; later changes on the command inputs SHALL have no effect on the scan in progress.
REQ-024 The DR sequence SHALL be tms 1 (Select-DR), 0 (Capture), 0 (Shift entry), then SHIFT for cmd_len ticks.
REQ-025 The IR sequence SHALL insert one extra tms=1 tick after Select-DR (Select-IR) and otherwise match the DR sequence.
REQ-026 In SHIFT, tick k (k = 0..len-1) SHALL drive tdi=data[k], with tms=0 for k<len-1 and tms=1 for k=len-1 (to Exit1).
REQ-027 After SHIFT the FSM SHALL issue one tick tms=1 (Update), then one tick tms=0 (Run-Test/Idle), then enter DONE.
REQ-028 tdi SHALL be 0 on all non-SHIFT ticks.
REQ-029 Total ticks per scan SHALL be len+5 for DR and len+6 for IR.
REQ-030 rsp_valid SHALL pulse in the clk cycle after the final tick's high phase, i.e. exactly ticks*2*CLK_DIV cycles after acceptance; DONE then returns to IDLE in the next cycle.
REQ-031 rsp_data[k] SHALL equal the tdo sampled in SHIFT tick k; bits len..37 SHALL be 0.
REQ-032 cmd_len=0 or cmd_len>MAX_LEN SHALL be accepted with no tck activity, and rsp_valid=1 with rsp_err=1 and rsp_data unchanged, one cycle after acceptance.
REQ-033 rsp_err SHALL be 0 on every legal completion.

Reset
REQ-034 On reset assertion, outputs SHALL immediately take these values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=1, state=TLR_SEQ.
REQ-035 Reset asserted mid-scan SHALL abandon the scan with no rsp_valid pulse; after release the FSM SHALL rerun TLR_SEQ (6 ticks) before cmd_ready rises.

Verification
REQ-036 Power-up, CLK_DIV=2: release reset -> tms=1 for 20 clk, tms=0 for 4 clk, cmd_ready=1 at cycle 24.
REQ-037 DR scan, tdo looped to tdi, len=38, data=0x2A_5A5A_A5A5 -> rsp_valid exactly 172 clk after accept, rsp_data=0x2A_5A5A_A5A5, rsp_err=0.
REQ-038 IR scan, len=2, data=2'b10, tdo tied 1 -> tms sequence 1,1,0,0,0,1,1,0, tdi=0 then 1 in shift, rsp_data=0x3, rsp_valid at 32 clk.
REQ-039 cmd_len=0 and cmd_len=39 -> no tck edges, rsp_valid with rsp_err=1 one cycle after accept, rsp_data unchanged.
REQ-040 Reset pulse during SHIFT tick 10 of a 38-bit DR -> no rsp_valid, full TLR_SEQ replayed, next scan (len=8, data=0xC3, loopback) returns 0xC3.
REQ-041 cmd_valid held high with changing cmd_data while busy -> only one accept per scan, tdi matches the data latched at acceptance, tms/tdi never change while tck=1.
